// File: rtl/memory_mc_align.sv
// memory_mc_align: multi-cycle big-endian byte-addressed memory with aligned word access; MEM_BYTE_WRITE_EN adds wr_mask
module memory_mc_align #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] wr_mask,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              done,
  output logic              err
);
  localparam int BW = DATA_W / 8;
  localparam int OW = $clog2(BW);
  localparam int IW = $clog2(DEPTH_BYTES);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [IW-1:0] a_q, e_a;
  logic [DATA_W-1:0] d_q, e_d, rd;
  logic [BW-1:0] m_q, e_m, mask;
  logic wr_q, mis_q, err_q, e_wr, e_mis, accept, fin;
  logic unused_addr;
  logic [7:0] mem [DEPTH_BYTES];
`ifdef MEM_BYTE_WRITE_EN
  assign mask = wr_mask;
`else
  assign mask = '1;
`endif
  assign unused_addr = ^addr[ADDR_W-1:IW];
  assign accept = enable && state != BUSY;
  assign stall = state == BUSY || accept;
  assign done = state == DONE;
  assign err = done && err_q;
  assign fin = LATENCY == 1 ? accept : state == BUSY && cnt == CW'(1);
  // A one-cycle access completes at acceptance, so its operands come straight from the ports
  assign e_a = LATENCY == 1 ? addr[IW-1:0] : a_q;
  assign e_d = LATENCY == 1 ? data_in : d_q;
  assign e_m = LATENCY == 1 ? mask : m_q;
  assign e_wr = LATENCY == 1 ? wr : wr_q;
  assign e_mis = LATENCY == 1 ? |addr[OW-1:0] : mis_q;
  // Next state: requests are taken in IDLE or DONE, BUSY runs out its counter
  always_comb begin
    nstate = IDLE;
    nstate = accept ? (LATENCY == 1 ? DONE : BUSY) : state == BUSY ? (fin ? DONE : BUSY) : IDLE;
  end
  // Big-endian gather: the byte at the word address lands in the MSBs
  always_comb begin
    rd = '0;
    for (int i = 0; i < BW; i++) rd[DATA_W-1-8*i -: 8] = mem[e_a + IW'(i)];
  end
  // State, latency counter, request latch and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      data_out <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        cnt <= CW'(LATENCY - 1);
        a_q <= addr[IW-1:0];
        d_q <= data_in;
        m_q <= mask;
        wr_q <= wr;
        mis_q <= |addr[OW-1:0];
      end else if (state == BUSY) cnt <= cnt - CW'(1);
      if (fin) begin
        err_q <= e_mis;
        if (e_mis || !e_wr) data_out <= e_mis ? '0 : rd;
      end
    end
  end
  // Storage commit on the edge entering DONE; contents survive reset, an aborting reset drops the write
  always_ff @(posedge clk) begin
    if (!rst && fin && e_wr && !e_mis)
      for (int i = 0; i < BW; i++) if (e_m[i]) mem[e_a + IW'(i)] <= e_d[DATA_W-1-8*i -: 8];
  end
endmodule

// File: tb/tb_memory_mc_align.sv
// tb_memory_mc_align: scoreboard bench for memory_mc_align with default parameters
module tb_memory_mc_align;
  localparam int LAT = 4;
  logic clk = 0, rst = 1, enable = 0, wr = 0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out;
  logic stall, done, err;
`ifdef MEM_BYTE_WRITE_EN
  logic [1:0] wr_mask = '1;
`endif
  typedef struct {logic [15:0] d; logic e; int c;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, dones = 0, pushed = 0, n0 = 0;

  memory_mc_align dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
`ifdef MEM_BYTE_WRITE_EN
    .wr_mask(wr_mask),
`endif
    .data_out(data_out), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      dones++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("data_out", data_out, e.d);
        chk("err", err, e.e);
        chk("latency", cyc - e.c, LAT);
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] ed, input logic ee, input bit track);
    enable = 1; wr = w; addr = a; data_in = d;
    if (track) begin
      q.push_back('{ed, ee, cyc});
      pushed++;
    end
    #1 chk("stall_accept", stall, 1);
    @(negedge clk);
    enable = 0; wr = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic op(input logic w, input logic [15:0] a, input logic [15:0] d,
                    input logic [15:0] ed, input logic ee);
    issue(w, a, d, ed, ee, 1);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data_out", data_out, 0);
    @(negedge clk);
    issue(1, 16'h0010, 16'hBEEF, 16'h0000, 0, 1);
    for (int i = 1; i < 4; i++) begin
      chk("busy_stall_nodone", {30'd0, stall, done}, 2);
      @(negedge clk);
    end
    wait_done();
    @(negedge clk);
    chk("idle_stall", stall, 0);
    op(0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    chk("mem_byte_0x10", dut.mem[16], 8'hBE);
    op(0, 16'h0011, 16'h0000, 16'h0000, 1);
    op(0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    op(1, 16'h0100, 16'h1234, 16'hBEEF, 0);
    op(0, 16'h0000, 16'h0000, 16'h1234, 0);
    issue(0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1);
    enable = 1; wr = 1; addr = 16'h0010; data_in = 16'hFFFF;
    #1 chk("stall_ignored", stall, 1);
    @(negedge clk);
    enable = 0; wr = 0;
    wait_done();
    issue(0, 16'h0000, 16'h0000, 16'h1234, 0, 1);
    wait_done();
    @(negedge clk);
    op(0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    op(1, 16'h0020, 16'h5555, 16'hBEEF, 0);
    issue(1, 16'h0020, 16'hAAAA, 16'h0000, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    n0 = dones;
    #1;
    chk("abort_data_out", data_out, 0);
    chk("abort_stall", stall, 0);
    repeat (8) @(negedge clk);
    chk("abort_no_done", dones, n0);
    op(0, 16'h0020, 16'h0000, 16'h5555, 0);
`ifdef MEM_BYTE_WRITE_EN
    wr_mask = 2'b11;
    op(1, 16'h0040, 16'h0000, 16'h5555, 0);
    wr_mask = 2'b01;
    op(1, 16'h0040, 16'hBEEF, 16'h5555, 0);
    wr_mask = 2'b11;
    op(0, 16'h0040, 16'h0000, 16'hBE00, 0);
`endif
    repeat (3) @(negedge clk);
    chk("done_count", dones, pushed);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
